// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction decoder: opcodes, instruction field
// positions, FSM state encoding and the per-opcode decode record.
package cpu_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SHL   = 4'h6;
    localparam logic [3:0] OP_SHR   = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_LDH   = 4'h9;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_CMP   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_BRZ   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    typedef struct packed {
        logic writes_rd;
        logic uses_imm;
        logic imm_high;
        logic is_halt;
    } op_info_t;

    // LDH places the byte in the upper half; everything else zero-extends.
    function automatic logic [15:0] extend_imm(input logic [7:0] imm8, input logic high);
        return high ? {imm8, 8'h00} : {8'h00, imm8};
    endfunction

endpackage

// File: rtl/decode_lut.sv
// Combinational opcode classifier: which opcodes write rD, carry an
// immediate (and in which byte), and which one halts the machine.
module decode_lut
    import cpu_pkg::*;
(
    input  logic [3:0] op_i,
    output op_info_t   info_o
);

    always_comb begin
        info_o = '0;
        case (op_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                info_o.writes_rd = 1'b1;
            end
            OP_LDI: begin
                info_o.writes_rd = 1'b1;
                info_o.uses_imm  = 1'b1;
            end
            OP_LDH: begin
                info_o.writes_rd = 1'b1;
                info_o.uses_imm  = 1'b1;
                info_o.imm_high  = 1'b1;
            end
            OP_LOAD: begin
                info_o.writes_rd = 1'b1;
                info_o.uses_imm  = 1'b1;
            end
            // Address-carrying ops expose imm8 but leave rD untouched.
            OP_STORE, OP_JMP, OP_BRZ: begin
                info_o.uses_imm = 1'b1;
            end
            OP_CMP: begin
                info_o = '0;
            end
            OP_HALT: begin
                info_o.is_halt = 1'b1;
            end
            default: begin
                info_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// Instruction decoder/sequencer: accepts one instruction at a time, drives the
// register file and ALU through DECODE/READ/EXEC, and writes the result back.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SEL_WIDTH   = 3,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   I_clk,
    input  logic                   I_reset,
    input  logic                   I_enable,
    input  logic [INSTR_WIDTH-1:0] I_instr,
    input  logic                   I_instr_valid,
    output logic                   O_instr_ready,
    output logic [SEL_WIDTH-1:0]   O_rA_select,
    output logic [SEL_WIDTH-1:0]   O_rB_select,
    output logic [SEL_WIDTH-1:0]   O_rD_select,
    output logic                   O_regfile_enable,
    output logic                   O_rD_write,
    output logic [DATA_WIDTH-1:0]  O_rD_in,
    output logic [3:0]             O_alu_op,
    output logic [DATA_WIDTH-1:0]  O_imm,
    output logic                   O_alu_start,
    input  logic                   I_alu_done,
    input  logic [DATA_WIDTH-1:0]  I_alu_result,
    output logic                   O_halt
);

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0]  rd_in_q;
    op_info_t               info;
    logic                   accept;
    logic                   capture_result;

    decode_lut u_decode_lut (
        .op_i   (instr_q[OP_MSB:OP_LSB]),
        .info_o (info)
    );

    assign accept         = I_instr_valid & O_instr_ready & I_enable;
    assign capture_result = I_enable & (state_q == ST_EXEC) & I_alu_done & info.writes_rd;

    // State register: a stall freezes the sequencer in whatever state it is in.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_q <= ST_IDLE;
        end else if (I_enable) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (I_instr_valid) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = info.is_halt ? ST_HALTED : ST_READ;
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (I_alu_done) begin
                    state_d = info.writes_rd ? ST_WB : ST_IDLE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Instruction latch and write-back data register.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            instr_q <= '0;
            rd_in_q <= '0;
        end else begin
            if (accept) begin
                instr_q <= I_instr;
            end
            if (capture_result) begin
                rd_in_q <= I_alu_result;
            end
        end
    end

    // Outputs: strobes come straight from the state register so a reset
    // kills an in-progress write without waiting for a clock edge.
    always_comb begin
        O_instr_ready    = (state_q == ST_IDLE);
        O_halt           = (state_q == ST_HALTED);
        O_regfile_enable = 1'b0;
        O_rD_write       = 1'b0;
        O_alu_start      = 1'b0;
        if (I_enable) begin
            case (state_q)
                ST_DECODE: O_regfile_enable = ~info.is_halt;
                ST_READ:   O_alu_start      = 1'b1;
                ST_WB: begin
                    O_regfile_enable = 1'b1;
                    O_rD_write       = 1'b1;
                end
                default: begin
                    O_regfile_enable = 1'b0;
                end
            endcase
        end
    end

    assign O_rD_select = instr_q[RD_MSB:RD_LSB];
    assign O_rA_select = instr_q[RA_MSB:RA_LSB];
    assign O_rB_select = instr_q[RB_MSB:RB_LSB];
    assign O_alu_op    = instr_q[OP_MSB:OP_LSB];
    assign O_rD_in     = rd_in_q;
    assign O_imm       = info.uses_imm
                       ? DATA_WIDTH'(extend_imm(instr_q[IMM_MSB:IMM_LSB], info.imm_high))
                       : '0;

endmodule
